// File: rtl/bcd_mod_counter_if.sv
// Bus bundle for bcd_mod_counter: control inputs, preset value and count/status outputs.
interface bcd_mod_counter_if #(
    parameter int DIGITS = 2
);
    logic                  en_sig;
    logic                  up_dn;
    logic                  load;
    logic [4*DIGITS-1:0]   load_bcd;
    logic [4*DIGITS-1:0]   cnt_bcd;
    logic                  carry_out;
    logic                  load_err;

    modport master (
        output en_sig, up_dn, load, load_bcd,
        input  cnt_bcd, carry_out, load_err
    );

    modport slave (
        input  en_sig, up_dn, load, load_bcd,
        output cnt_bcd, carry_out, load_err
    );
endinterface

// File: rtl/bcd_mod_counter.sv
// Multi-digit packed-BCD modulo counter (0..MOD_VAL-1), up/down, with checked
// synchronous preset and a combinational terminal-count output for cascading.
module bcd_mod_counter #(
    parameter int DIGITS  = 2,
    parameter int MOD_VAL = 60,
    parameter int RST_VAL = 0
) (
    input  logic               clk,
    input  logic               rst,
    bcd_mod_counter_if.slave   bus
);
    localparam int W = 4 * DIGITS;

    // Decimal to packed BCD, used only on constants at elaboration time.
    function automatic logic [W-1:0] to_bcd(input int unsigned value);
        logic [W-1:0] r;
        int unsigned  v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 32'd10);
            v = v / 32'd10;
        end
        return r;
    endfunction

    // True when every nibble is a decimal digit.
    function automatic logic digits_ok(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            ok = ok & (v[4*i +: 4] <= 4'd9);
        end
        return ok;
    endfunction

    // Digit-wise BCD increment with ripple carry.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Digit-wise BCD decrement with ripple borrow.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Terminal patterns fixed at elaboration.
    localparam logic [W-1:0] MAX_BCD  = to_bcd(32'(MOD_VAL - 1));
    localparam logic [W-1:0] RST_BCD  = to_bcd(32'(RST_VAL));
    localparam logic [W-1:0] ZERO_BCD = '0;

    logic [W-1:0] cnt_r;
    logic         err_r;
    logic [W-1:0] step_s;
    logic [W-1:0] next_cnt_s;
    logic         next_err_s;
    logic         cnt_zero_s;
    logic         cnt_max_s;
    logic         cnt_legal_s;
    logic         load_ok_s;

    // Status decode. With all nibbles valid, packed-BCD order equals decimal
    // order, so a plain unsigned compare against MAX_BCD gives "value < MOD_VAL".
    always_comb begin
        cnt_zero_s  = (cnt_r == ZERO_BCD);
        cnt_max_s   = (cnt_r == MAX_BCD);
        cnt_legal_s = digits_ok(cnt_r) & (cnt_r <= MAX_BCD);
        load_ok_s   = digits_ok(bus.load_bcd) & (bus.load_bcd <= MAX_BCD);
    end

    // Value the counter would take on a step; an illegal state always recovers to 0.
    always_comb begin
        step_s = ZERO_BCD;
        if (!cnt_legal_s) begin
            step_s = ZERO_BCD;
        end else if (bus.up_dn) begin
            if (cnt_max_s) begin
                step_s = ZERO_BCD;
            end else begin
                step_s = bcd_inc(cnt_r);
            end
        end else begin
            if (cnt_zero_s) begin
                step_s = MAX_BCD;
            end else begin
                step_s = bcd_dec(cnt_r);
            end
        end
    end

    // Next-state selection: load beats step beats hold; a rejected load blocks the step.
    always_comb begin
        next_cnt_s = cnt_r;
        next_err_s = 1'b0;
        if (bus.load) begin
            if (load_ok_s) begin
                next_cnt_s = bus.load_bcd;
                next_err_s = 1'b0;
            end else begin
                next_cnt_s = cnt_r;
                next_err_s = 1'b1;
            end
        end else if (bus.en_sig) begin
            next_cnt_s = step_s;
            next_err_s = 1'b0;
        end else begin
            next_cnt_s = cnt_r;
            next_err_s = 1'b0;
        end
    end

    // Count and error-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= RST_BCD;
            err_r <= 1'b0;
        end else begin
            cnt_r <= next_cnt_s;
            err_r <= next_err_s;
        end
    end

    assign bus.cnt_bcd   = cnt_r;
    assign bus.load_err  = err_r;
    // Mealy terminal count: high in the cycle before a wrap so the next stage steps on the same edge.
    assign bus.carry_out = bus.en_sig & ~bus.load &
                           ((bus.up_dn & cnt_max_s) | (~bus.up_dn & cnt_zero_s));
endmodule

// File: tb/tb_bcd_mod_counter.sv
// Self-checking bench for bcd_mod_counter: directed scenarios plus randomized
// stimulus against a decimal-arithmetic reference model.
module tb_bcd_mod_counter;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    bcd_mod_counter_if #(.DIGITS(2)) if60 ();
    bcd_mod_counter_if #(.DIGITS(2)) if24 ();
    bcd_mod_counter_if #(.DIGITS(3)) if3  ();
    bcd_mod_counter_if #(.DIGITS(2)) ifs  ();
    bcd_mod_counter_if #(.DIGITS(2)) ifm  ();

    bcd_mod_counter #(.DIGITS(2), .MOD_VAL(60),  .RST_VAL(12)) u60 (.clk(clk), .rst(rst), .bus(if60.slave));
    bcd_mod_counter #(.DIGITS(2), .MOD_VAL(24),  .RST_VAL(0))  u24 (.clk(clk), .rst(rst), .bus(if24.slave));
    bcd_mod_counter #(.DIGITS(3), .MOD_VAL(250), .RST_VAL(7))  u3  (.clk(clk), .rst(rst), .bus(if3.slave));
    bcd_mod_counter #(.DIGITS(2), .MOD_VAL(60),  .RST_VAL(0))  us  (.clk(clk), .rst(rst), .bus(ifs.slave));
    bcd_mod_counter #(.DIGITS(2), .MOD_VAL(60),  .RST_VAL(0))  um  (.clk(clk), .rst(rst), .bus(ifm.slave));

    // Minutes stage steps whenever seconds stage signals terminal count.
    assign ifm.en_sig = ifs.carry_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference helpers: plain decimal arithmetic.
    function automatic int to_bcd(int v);
        int r;
        r = 0;
        for (int i = 0; i < 6; i++) begin
            r = r | ((v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int bcd_value(int b, int digits);
        int v;
        int scale;
        int d;
        v = 0;
        scale = 1;
        for (int i = 0; i < digits; i++) begin
            d = (b >> (4 * i)) & 15;
            if (d > 9) return -1;
            v = v + d * scale;
            scale = scale * 10;
        end
        return v;
    endfunction

    function automatic int gen_load(int mod, int digits);
        int kind;
        int top;
        int mask;
        kind = int'($urandom_range(0, 3));
        top  = 10 ** digits;
        mask = (1 << (4 * digits)) - 1;
        if (kind <= 1) return to_bcd(int'($urandom_range(0, mod - 1)));
        if (kind == 2 && mod < top) return to_bcd(int'($urandom_range(mod, top - 1)));
        return int'($urandom) & mask;
    endfunction

    task automatic drive60(input logic en, input logic up, input logic ld, input logic [7:0] v);
        if60.en_sig = en; if60.up_dn = up; if60.load = ld; if60.load_bcd = v;
    endtask

    task automatic drive24(input logic en, input logic up, input logic ld, input logic [7:0] v);
        if24.en_sig = en; if24.up_dn = up; if24.load = ld; if24.load_bcd = v;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (if60.cnt_bcd !== 8'h12) begin errors++; $display("FAIL reset_cnt60 got=%h exp=12", if60.cnt_bcd); end
        checks++; if (if60.load_err !== 1'b0) begin errors++; $display("FAIL reset_err60 got=%b exp=0", if60.load_err); end
        checks++; if (if24.cnt_bcd !== 8'h00) begin errors++; $display("FAIL reset_cnt24 got=%h exp=00", if24.cnt_bcd); end
        checks++; if (if3.cnt_bcd !== 12'h007) begin errors++; $display("FAIL reset_cnt3 got=%h exp=007", if3.cnt_bcd); end
        checks++; if (if60.carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry60 got=%b exp=0", if60.carry_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_up_60();
        logic exp_c;
        @(negedge clk); drive60(1'b0, 1'b1, 1'b1, 8'h00);
        @(negedge clk); drive60(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i <= 60; i++) begin
            #1;
            exp_c = ((i % 60) == 59);
            checks++; if (if60.cnt_bcd !== 8'(to_bcd(i % 60))) begin errors++; $display("FAIL up60_cnt step=%0d got=%h exp=%h", i, if60.cnt_bcd, 8'(to_bcd(i % 60))); end
            checks++; if (if60.carry_out !== exp_c) begin errors++; $display("FAIL up60_carry step=%0d got=%b exp=%b", i, if60.carry_out, exp_c); end
            @(negedge clk);
        end
        drive60(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_down_60();
        int e;
        logic exp_c;
        @(negedge clk); drive60(1'b0, 1'b0, 1'b1, 8'h10);
        @(negedge clk); drive60(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 10; i >= -2; i--) begin
            #1;
            e = (i + 60) % 60;
            exp_c = (e == 0);
            checks++; if (if60.cnt_bcd !== 8'(to_bcd(e))) begin errors++; $display("FAIL down60_cnt got=%h exp=%h", if60.cnt_bcd, 8'(to_bcd(e))); end
            checks++; if (if60.carry_out !== exp_c) begin errors++; $display("FAIL down60_carry cnt=%h got=%b exp=%b", if60.cnt_bcd, if60.carry_out, exp_c); end
            @(negedge clk);
        end
        drive60(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_mod24();
        @(negedge clk); drive24(1'b0, 1'b1, 1'b1, 8'h23);
        @(negedge clk); drive24(1'b1, 1'b1, 1'b1, 8'h24);
        #1;
        checks++; if (if24.carry_out !== 1'b0) begin errors++; $display("FAIL m24_carry_load got=%b exp=0", if24.carry_out); end
        @(negedge clk);
        checks++; if (if24.cnt_bcd !== 8'h23) begin errors++; $display("FAIL m24_badload_hold got=%h exp=23", if24.cnt_bcd); end
        checks++; if (if24.load_err !== 1'b1) begin errors++; $display("FAIL m24_err_set got=%b exp=1", if24.load_err); end
        drive24(1'b1, 1'b1, 1'b0, 8'h00);
        #1;
        checks++; if (if24.carry_out !== 1'b1) begin errors++; $display("FAIL m24_carry23 got=%b exp=1", if24.carry_out); end
        @(negedge clk);
        checks++; if (if24.cnt_bcd !== 8'h00) begin errors++; $display("FAIL m24_wrap got=%h exp=00", if24.cnt_bcd); end
        checks++; if (if24.load_err !== 1'b0) begin errors++; $display("FAIL m24_err_clear got=%b exp=0", if24.load_err); end
        drive24(1'b0, 1'b1, 1'b1, 8'h24);
        @(negedge clk);
        checks++; if (if24.cnt_bcd !== 8'h00) begin errors++; $display("FAIL m24_load24_hold got=%h exp=00", if24.cnt_bcd); end
        checks++; if (if24.load_err !== 1'b1) begin errors++; $display("FAIL m24_load24_err got=%b exp=1", if24.load_err); end
        drive24(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        checks++; if (if24.load_err !== 1'b0) begin errors++; $display("FAIL m24_err_pulse got=%b exp=0", if24.load_err); end
    endtask

    task automatic test_bad_nibble();
        @(negedge clk); drive60(1'b0, 1'b1, 1'b1, 8'h20);
        @(negedge clk); drive60(1'b0, 1'b1, 1'b1, 8'h3A);
        @(negedge clk);
        checks++; if (if60.cnt_bcd !== 8'h20) begin errors++; $display("FAIL nib_hold got=%h exp=20", if60.cnt_bcd); end
        checks++; if (if60.load_err !== 1'b1) begin errors++; $display("FAIL nib_err got=%b exp=1", if60.load_err); end
        drive60(1'b1, 1'b1, 1'b1, 8'h45);
        @(negedge clk);
        checks++; if (if60.cnt_bcd !== 8'h45) begin errors++; $display("FAIL load45_en got=%h exp=45", if60.cnt_bcd); end
        checks++; if (if60.load_err !== 1'b0) begin errors++; $display("FAIL load45_err got=%b exp=0", if60.load_err); end
        drive60(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_async_reset();
        @(negedge clk); drive60(1'b0, 1'b1, 1'b1, 8'h37);
        @(negedge clk); drive60(1'b0, 1'b1, 1'b1, 8'h99);
        @(negedge clk); drive60(1'b0, 1'b1, 1'b0, 8'h00);
        checks++; if (if60.cnt_bcd !== 8'h37) begin errors++; $display("FAIL rst_pre_cnt got=%h exp=37", if60.cnt_bcd); end
        checks++; if (if60.load_err !== 1'b1) begin errors++; $display("FAIL rst_pre_err got=%b exp=1", if60.load_err); end
        #2 rst = 1'b1;
        drive60(1'b1, 1'b1, 1'b0, 8'h00);
        #1;
        checks++; if (if60.cnt_bcd !== 8'h12) begin errors++; $display("FAIL rst_async_cnt got=%h exp=12", if60.cnt_bcd); end
        checks++; if (if60.load_err !== 1'b0) begin errors++; $display("FAIL rst_async_err got=%b exp=0", if60.load_err); end
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (if60.cnt_bcd !== 8'h13) begin errors++; $display("FAIL rst_resume got=%h exp=13", if60.cnt_bcd); end
        drive60(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_cascade();
        @(negedge clk);
        ifs.en_sig = 1'b0; ifs.up_dn = 1'b1; ifs.load = 1'b1; ifs.load_bcd = 8'h58;
        ifm.up_dn = 1'b1; ifm.load = 1'b1; ifm.load_bcd = 8'h59;
        @(negedge clk);
        ifs.load = 1'b0; ifm.load = 1'b0; ifs.en_sig = 1'b1;
        #1;
        checks++; if (ifm.carry_out !== 1'b0) begin errors++; $display("FAIL casc_min_carry_early got=%b exp=0", ifm.carry_out); end
        @(negedge clk);
        checks++; if ({ifm.cnt_bcd, ifs.cnt_bcd} !== 16'h5959) begin errors++; $display("FAIL casc_5959 got=%h exp=5959", {ifm.cnt_bcd, ifs.cnt_bcd}); end
        #1;
        checks++; if (ifs.carry_out !== 1'b1) begin errors++; $display("FAIL casc_sec_carry got=%b exp=1", ifs.carry_out); end
        checks++; if (ifm.carry_out !== 1'b1) begin errors++; $display("FAIL casc_min_carry got=%b exp=1", ifm.carry_out); end
        @(negedge clk);
        checks++; if ({ifm.cnt_bcd, ifs.cnt_bcd} !== 16'h0000) begin errors++; $display("FAIL casc_wrap got=%h exp=0000", {ifm.cnt_bcd, ifs.cnt_bcd}); end
        #1;
        checks++; if (ifm.carry_out !== 1'b0) begin errors++; $display("FAIL casc_min_carry_after got=%b exp=0", ifm.carry_out); end
        ifs.en_sig = 1'b0;
    endtask

    task automatic test_random();
        int m60, e60, m3, e3, lv60, lv3, v;
        logic en60, up60, ld60, en3, up3, ld3, c60, c3;
        @(negedge clk);
        drive60(1'b0, 1'b1, 1'b1, 8'h33);
        if3.en_sig = 1'b0; if3.up_dn = 1'b1; if3.load = 1'b1; if3.load_bcd = 12'h248;
        m60 = 33; e60 = 0; m3 = 248; e3 = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            checks++; if (if60.cnt_bcd !== 8'(to_bcd(m60))) begin errors++; $display("FAIL rnd60_cnt n=%0d got=%h exp=%h", n, if60.cnt_bcd, 8'(to_bcd(m60))); end
            checks++; if (if60.load_err !== e60[0]) begin errors++; $display("FAIL rnd60_err n=%0d got=%b exp=%0d", n, if60.load_err, e60); end
            checks++; if (if3.cnt_bcd !== 12'(to_bcd(m3))) begin errors++; $display("FAIL rnd3_cnt n=%0d got=%h exp=%h", n, if3.cnt_bcd, 12'(to_bcd(m3))); end
            checks++; if (if3.load_err !== e3[0]) begin errors++; $display("FAIL rnd3_err n=%0d got=%b exp=%0d", n, if3.load_err, e3); end
            en60 = ($urandom_range(0, 3) != 0); up60 = 1'($urandom); ld60 = ($urandom_range(0, 4) == 0);
            en3  = ($urandom_range(0, 3) != 0); up3  = 1'($urandom); ld3  = ($urandom_range(0, 4) == 0);
            lv60 = gen_load(60, 2); lv3 = gen_load(250, 3);
            drive60(en60, up60, ld60, 8'(lv60));
            if3.en_sig = en3; if3.up_dn = up3; if3.load = ld3; if3.load_bcd = 12'(lv3);
            #1;
            c60 = en60 && !ld60 && ((up60 && m60 == 59) || (!up60 && m60 == 0));
            c3  = en3 && !ld3 && ((up3 && m3 == 249) || (!up3 && m3 == 0));
            checks++; if (if60.carry_out !== c60) begin errors++; $display("FAIL rnd60_carry n=%0d got=%b exp=%b", n, if60.carry_out, c60); end
            checks++; if (if3.carry_out !== c3) begin errors++; $display("FAIL rnd3_carry n=%0d got=%b exp=%b", n, if3.carry_out, c3); end
            if (ld60) begin
                v = bcd_value(lv60, 2);
                if (v >= 0 && v < 60) begin m60 = v; e60 = 0; end else e60 = 1;
            end else begin
                e60 = 0;
                if (en60) m60 = up60 ? (m60 + 1) % 60 : (m60 + 59) % 60;
            end
            if (ld3) begin
                v = bcd_value(lv3, 3);
                if (v >= 0 && v < 250) begin m3 = v; e3 = 0; end else e3 = 1;
            end else begin
                e3 = 0;
                if (en3) m3 = up3 ? (m3 + 1) % 250 : (m3 + 249) % 250;
            end
        end
        @(negedge clk);
        drive60(1'b0, 1'b1, 1'b0, 8'h00);
        if3.en_sig = 1'b0; if3.load = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive60(1'b0, 1'b1, 1'b0, 8'h00);
        drive24(1'b0, 1'b1, 1'b0, 8'h00);
        if3.en_sig = 1'b0; if3.up_dn = 1'b1; if3.load = 1'b0; if3.load_bcd = 12'h000;
        ifs.en_sig = 1'b0; ifs.up_dn = 1'b1; ifs.load = 1'b0; ifs.load_bcd = 8'h00;
        ifm.up_dn = 1'b1; ifm.load = 1'b0; ifm.load_bcd = 8'h00;
        #10;
        test_reset();
        test_up_60();
        test_down_60();
        test_mod24();
        test_bad_nibble();
        test_async_reset();
        test_cascade();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd_mod_counter.md
# bcd_mod_counter

Parametrised multi-digit BCD modulo counter for the watch datapath. Counts 0 to MOD_VAL-1 in packed BCD, up or down. Supports synchronous preset with validity checking and a combinational terminal-count output for cascading. One instance serves as seconds/minutes (MOD_VAL=60), hours (24 or 12), or any digit chain up to DIGITS decades.

## Interface
- DIGITS, 2, number of BCD decades; legal range 1..6.
- MOD_VAL, 60, modulus; count range 0..MOD_VAL-1; legal range 2..10^DIGITS.
- RST_VAL, 0, decimal value loaded on reset; must satisfy RST_VAL < MOD_VAL.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- en_sig  input  1  count enable; one step per clock while high.
- up_dn  input  1  direction: 1 = up, 0 = down; sampled only when a step occurs.
- load  input  1  synchronous preset request.
- load_bcd  input  4*DIGITS  preset value, packed BCD, digit 0 = bits [3:0].
- cnt_bcd  output  4*DIGITS  current count, packed BCD, registered.
- carry_out  output  1  terminal count, combinational (Mealy).
- load_err  output  1  registered one-cycle flag: last load was rejected.

## Operation
- Reset (rst=1, asynchronous): cnt_bcd = BCD(RST_VAL), load_err = 0. carry_out follows its equation from the reset count.
- Priority per clock edge: load > en_sig > hold.
- Load, valid: every nibble of load_bcd ≤ 9 and decimal value < MOD_VAL. cnt_bcd <= load_bcd; load_err <= 0.
- Load, invalid: any nibble ≥ 10, or value ≥ MOD_VAL. cnt_bcd holds; load_err <= 1 for one cycle.
- Step up (en_sig=1, load=0, up_dn=1):
  - If cnt = MOD_VAL-1, cnt <= 0.
  - Else increment digit 0. A digit at 9 goes to 0 and carries into the next digit. Ripple is digit-wise BCD; no binary conversion.
- Step down (en_sig=1, load=0, up_dn=0):
  - If cnt = 0, cnt <= BCD(MOD_VAL-1).
  - Else decrement digit 0. A digit at 0 goes to 9 and borrows from the next digit.
- Hold: en_sig=0 and load=0. cnt_bcd unchanged; load_err <= 0.
- carry_out = en_sig & ~load & ((up_dn & cnt = MOD_VAL-1) | (~up_dn & cnt = 0)).
  - Cascading: drive the next stage's en_sig with carry_out. The next stage steps on the same edge that this stage wraps.
- Terminal comparisons use constant BCD patterns derived from MOD_VAL at elaboration time.
- Digits above the highest digit of MOD_VAL-1 stay 0 in every reachable state.
- If an illegal state is forced in (not reachable), the next step goes to 0, regardless of direction.

## Timing
- cnt_bcd changes only on the rising clk edge, or immediately on rst assertion.
- Step latency: en_sig high at edge N produces the new count after edge N.
- load_err is valid in the cycle after the rejected load edge and is cleared by the following edge.
- carry_out is combinational from en_sig, load, up_dn and cnt_bcd, with no register stage. It is high during the cycle before the wrap edge.
- Direction change with en_sig high: takes effect on that same edge. No dead cycle.
- Reset mid-count: count goes to RST_VAL immediately. On rst deassertion, the first step happens on the first edge with en_sig=1.
- Load while en_sig=1:
  - Valid load: load wins, no step.
  - Invalid load: no load and no step; count holds.

## Test plan
- MOD_VAL=60, up, en_sig held:
  - 00→01…→59→00.
  - carry_out high exactly in the cycle where cnt=59.
  - 09→10 shows a correct digit carry.
- MOD_VAL=60, down from 00:
  - Next count is 59; carry_out is high while cnt=00.
  - 10→09 shows a correct borrow.
- MOD_VAL=24, DIGITS=2, up from 23:
  - Next count is 00, not 24.
  - Loading 0x24 leaves the count unchanged and load_err=1 for one cycle.
- Loading 0x3A (nibble > 9) into a 60-counter:
  - Rejected, load_err pulse.
  - Loading 0x45 with en_sig=1 gives cnt=0x45, no step, load_err=0.
- Reset: assert rst asynchronously between edges with cnt=0x37 and RST_VAL=12.
  - cnt_bcd=0x12 before the next edge; load_err=0.
  - Counting resumes at 13 after release.
- Cascade: seconds (60) carry_out drives minutes (60) en_sig, started at 59:59 counting up.
  - One edge gives 00:00.
  - Minutes carry_out is high only in that final cycle.
